// File: rtl/imem_arbiter_if.sv
// Instruction-memory arbiter bus: fetch port, loader port and BRAM port.
// slave is the arbiter side, master is the surrounding system.
interface imem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              f_req;
    logic [31:0]       f_addr;
    logic [DATA_W-1:0] f_rdata;
    logic              f_valid;
    logic              f_stall;
    logic              l_req;
    logic [31:0]       l_addr;
    logic [DATA_W-1:0] l_wdata;
    logic              l_ack;
    logic              l_done;
    logic              cpu_run;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  f_req, f_addr, l_req, l_addr, l_wdata,
        input  l_done, mem_rdata,
        output f_rdata, f_valid, f_stall, l_ack, cpu_run,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output f_req, f_addr, l_req, l_addr, l_wdata,
        output l_done, mem_rdata,
        input  f_rdata, f_valid, f_stall, l_ack, cpu_run,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_arbiter.sv
// Single-port BRAM arbiter: loader owns the port in BOOT, fetch has
// priority in RUN with a bounded deferral of pending loader writes.
module imem_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input logic          clk,
    input logic          reset,
    imem_arbiter_if.slave bus
);
    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic            f_valid_q;
    logic            f_gnt;
    logic            l_gnt;
    logic [ADDR_W-1:0] f_word;
    logic [ADDR_W-1:0] l_word;
    logic            unused_addr;

    // Word addressing wraps: low byte bits and high bits are dropped.
    assign f_word = bus.f_addr[ADDR_W+1:2];
    assign l_word = bus.l_addr[ADDR_W+1:2];
    assign unused_addr = ^{bus.f_addr[31:ADDR_W+2], bus.f_addr[1:0],
                           bus.l_addr[31:ADDR_W+2], bus.l_addr[1:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == BOOT && bus.l_done) begin
            state_d = RUN;
        end
    end

    always_comb begin
        f_gnt = 1'b0;
        l_gnt = 1'b0;
        unique case (state_q)
            BOOT: begin
                l_gnt = bus.l_req;
            end
            RUN: begin
                f_gnt = bus.f_req && !(bus.l_req && cnt_q == SMAX);
                l_gnt = bus.l_req && !f_gnt;
            end
        endcase

        cnt_d = '0;
        if (state_q == RUN && bus.l_req && f_gnt) begin
            cnt_d = cnt_q + CW'(1);
        end

        bus.mem_en    = f_gnt || l_gnt;
        bus.mem_we    = l_gnt;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (l_gnt) begin
            bus.mem_addr  = l_word;
            bus.mem_wdata = bus.l_wdata;
        end else if (f_gnt) begin
            bus.mem_addr  = f_word;
        end

        bus.l_ack   = l_gnt;
        bus.f_stall = bus.f_req && !f_gnt;
        bus.f_valid = f_valid_q;
        bus.f_rdata = f_valid_q ? bus.mem_rdata : '0;
        bus.cpu_run = (state_q == RUN);
    end

    // A read in flight when reset hits is dropped with f_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            f_valid_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            f_valid_q <= f_gnt;
        end
    end
endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: vector table plus starvation sequences.
// Includes a behavioural 1-cycle-latency BRAM model.
module tb_imem_arbiter;
    localparam int AW = 8;
    localparam int DW = 32;

    logic clk;
    logic reset;

    imem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    imem_arbiter #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .STARVE_MAX(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] ram [256];

    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata <= ram[bus.mem_addr];
        end
    end

    typedef struct {
        logic        rst;
        logic        f_req;
        logic [31:0] f_addr;
        logic        l_req;
        logic [31:0] l_addr;
        logic [31:0] l_wdata;
        logic        l_done;
        logic [77:0] exp;
    } vec_t;

    vec_t tbl[$];
    int n_cmp = 0;
    int n_bad = 0;

    // {stall, ack, en, we, addr, wdata, valid, rdata, run}
    function automatic logic [77:0] o(
        logic st, logic ak, logic en, logic we,
        logic [7:0] ad, logic [31:0] wd,
        logic fv, logic [31:0] rd, logic rn
    );
        return {st, ak, en, we, ad, wd, fv, rd, rn};
    endfunction

    function automatic vec_t v(
        logic rs, logic fr, logic [31:0] fa,
        logic lr, logic [31:0] la, logic [31:0] lw,
        logic ld, logic [77:0] e
    );
        vec_t t;
        t.rst = rs; t.f_req = fr; t.f_addr = fa;
        t.l_req = lr; t.l_addr = la; t.l_wdata = lw;
        t.l_done = ld; t.exp = e;
        return t;
    endfunction

    function automatic logic [77:0] actual();
        return {bus.f_stall, bus.l_ack, bus.mem_en, bus.mem_we,
                bus.mem_addr, bus.mem_wdata, bus.f_valid,
                bus.f_rdata, bus.cpu_run};
    endfunction

    task automatic drive(vec_t t);
        reset      = t.rst;
        bus.f_req  = t.f_req;
        bus.f_addr = t.f_addr;
        bus.l_req  = t.l_req;
        bus.l_addr = t.l_addr;
        bus.l_wdata = t.l_wdata;
        bus.l_done = t.l_done;
    endtask

    task automatic starve(string nm, int want);
        int k;
        logic st;
        k = 20;
        st = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            reset = 1'b0;
            bus.f_req = 1'b1;
            bus.f_addr = 32'h0;
            bus.l_req = 1'b1;
            bus.l_addr = 32'h20;
            bus.l_wdata = 32'hA5A5_0000 + i;
            bus.l_done = 1'b0;
            #1;
            if (bus.l_ack) begin
                k = i;
                st = bus.f_stall;
                break;
            end
        end
        n_cmp++;
        if (k != want) begin
            n_bad++;
            $display("FAIL %s wait: got %0d want %0d", nm, k, want);
        end
        n_cmp++;
        if (st !== 1'b1) begin
            n_bad++;
            $display("FAIL %s stall at ack: got %b want 1", nm, st);
        end
        @(negedge clk);
        bus.l_req = 1'b0;
    endtask

    localparam logic [31:0] W0 = 32'h0050_0113;
    localparam logic [31:0] W1 = 32'h00C0_0193;
    localparam logic [31:0] W2 = 32'h0020_8233;
    localparam logic [31:0] WB = 32'hDEAD_BEEF;
    localparam logic [31:0] W4 = 32'h1111_1111;
    localparam logic [31:0] W5 = 32'h2222_2222;

    initial begin
        logic [77:0] m;
        logic [77:0] a;
        for (int i = 0; i < 256; i++) ram[i] = '0;
        bus.mem_rdata = '0;
        drive(v(1, 0, 0, 0, 0, 0, 0, '0));
        repeat (2) @(negedge clk);

        // Reset and BOOT
        tbl.push_back(v(1, 1, 0, 0, 0, 0, 0,
            o(1, 0, 0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 0,
            o(1, 0, 0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(v(0, 1, 0, 1, 32'h0, W0, 0,
            o(1, 1, 1, 1, 0, W0, 0, 0, 0)));
        tbl.push_back(v(0, 1, 0, 1, 32'h4, W1, 0,
            o(1, 1, 1, 1, 1, W1, 0, 0, 0)));
        tbl.push_back(v(0, 1, 0, 1, 32'h8, W2, 0,
            o(1, 1, 1, 1, 2, W2, 0, 0, 0)));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 0,
            o(1, 0, 0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 1,
            o(0, 0, 0, 0, 0, 0, 0, 0, 0)));
        // RUN: streaming fetch, wrap at 0x400
        tbl.push_back(v(0, 1, 32'h0, 0, 0, 0, 0,
            o(0, 0, 1, 0, 0, 0, 0, 0, 1)));
        tbl.push_back(v(0, 1, 32'h4, 0, 0, 0, 0,
            o(0, 0, 1, 0, 1, 0, 1, W0, 1)));
        tbl.push_back(v(0, 1, 32'h8, 0, 0, 0, 0,
            o(0, 0, 1, 0, 2, 0, 1, W1, 1)));
        tbl.push_back(v(0, 1, 32'h400, 0, 0, 0, 0,
            o(0, 0, 1, 0, 0, 0, 1, W2, 1)));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0,
            o(0, 0, 0, 0, 0, 0, 1, W0, 1)));
        // Starvation: four fetches, then the write
        tbl.push_back(v(0, 1, 32'h4, 1, 32'hC, WB, 0,
            o(0, 0, 1, 0, 1, 0, 0, 0, 1)));
        tbl.push_back(v(0, 1, 32'h4, 1, 32'hC, WB, 0,
            o(0, 0, 1, 0, 1, 0, 1, W1, 1)));
        tbl.push_back(v(0, 1, 32'h4, 1, 32'hC, WB, 0,
            o(0, 0, 1, 0, 1, 0, 1, W1, 1)));
        tbl.push_back(v(0, 1, 32'h4, 1, 32'hC, WB, 0,
            o(0, 0, 1, 0, 1, 0, 1, W1, 1)));
        tbl.push_back(v(0, 1, 32'h4, 1, 32'hC, WB, 0,
            o(1, 1, 1, 1, 3, WB, 1, W1, 1)));
        // Fetch of the just-written word
        tbl.push_back(v(0, 1, 32'hC, 0, 0, 0, 0,
            o(0, 0, 1, 0, 3, 0, 0, 0, 1)));
        tbl.push_back(v(0, 0, 0, 1, 32'h10, W4, 0,
            o(0, 1, 1, 1, 4, W4, 1, WB, 1)));
        tbl.push_back(v(0, 1, 32'h10, 0, 0, 0, 1,
            o(0, 0, 1, 0, 4, 0, 0, 0, 1)));
        // Reset right after a fetch grant
        tbl.push_back(v(1, 1, 32'h0, 0, 0, 0, 0,
            o(0, 0, 1, 0, 0, 0, 1, W4, 1)));
        tbl.push_back(v(0, 1, 32'h0, 0, 0, 0, 0,
            o(1, 0, 0, 0, 0, 0, 0, 0, 0)));
        // Write and l_done in the same BOOT cycle
        tbl.push_back(v(0, 0, 0, 1, 32'h14, W5, 1,
            o(0, 1, 1, 1, 5, W5, 0, 0, 0)));
        tbl.push_back(v(0, 1, 32'h14, 0, 0, 0, 0,
            o(0, 0, 1, 0, 5, 0, 0, 0, 1)));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0,
            o(0, 0, 0, 0, 0, 0, 1, W5, 1)));

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            m = '1;
            if (i != 0) begin
                if (!tbl[i].exp[75]) m[73:66] = '0;
                if (!tbl[i].exp[74]) m[65:34] = '0;
            end
            a = actual();
            n_cmp++;
            if ((a & m) !== (tbl[i].exp & m)) begin
                n_bad++;
                $display("FAIL vec%0d: got %h want %h", i,
                         a & m, tbl[i].exp & m);
            end
        end

        starve("starve_a", 4);
        // Dropping l_req mid-count must restart the deferral window
        @(negedge clk);
        bus.f_req = 1'b1;
        bus.l_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.l_req = 1'b0;
        starve("starve_b", 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
